axi4_lite_read_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite read-channel arbiter. It shares the single AXI4-Lite read slave between the instruction-fetch port (M0) and the load/store port (M1). It sits between the two core-side read masters and the read slave that fronts memory. It allows one outstanding transaction at a time and uses round-robin grant with the tie going to M0 after reset.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/axi4_lite_read_arbiter.sv | 130 +++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite read-arbiter definitions: FSM states, response codes, master indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam int M0 = 0;
  localparam int M1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one not in last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; gnt is recomputed every cycle from req and last.
//
// Ports:
//   req  in  2  request vector {M1,M0}
//   last in  2  one-hot master granted most recently
//   gnt  out 2  one-hot grant, 2'b00 when nobody requests
module rr_arb2
  import axi4_lite_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[M0] && !req[M1]) begin
      gnt[M0] = 1'b1;
    end else if (req[M1] && !req[M0]) begin
      gnt[M1] = 1'b1;
    end else if (req[M0] && req[M1]) begin
      // M0 wins unless it was the previous owner; also covers last==00.
      if (last[M0]) gnt[M1] = 1'b1;
      else          gnt[M0] = 1'b1;
    end
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-Lite read slave between IFU (M0) and LSU (M1), one transaction in flight.
// Latency: AR accepted in IDLE, S_AR_VALID one cycle later; R path is a zero-cycle passthrough.
// Backpressure: holds ADDR until S_AR_READY and DATA until owner R handshake; AR_READY low outside IDLE.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   M0_AR_*/M0_R_*, M1_AR_*/M1_R_*  upstream read masters (AR in, R out)
//   S_AR_*/S_R_*                  downstream read slave
//   GRANT                         one-hot current owner {M1,M0}, 00 when idle
//   BUSY                          high while in ADDR or DATA
module axi4_lite_read_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic [ADDR_W-1:0] M0_AR_ADDR,
  input  logic              M0_AR_VALID,
  output logic              M0_AR_READY,
  output logic [DATA_W-1:0] M0_R_DATA,
  output logic [1:0]        M0_R_RESP,
  output logic              M0_R_VALID,
  input  logic              M0_R_READY,

  input  logic [ADDR_W-1:0] M1_AR_ADDR,
  input  logic              M1_AR_VALID,
  output logic              M1_AR_READY,
  output logic [DATA_W-1:0] M1_R_DATA,
  output logic [1:0]        M1_R_RESP,
  output logic              M1_R_VALID,
  input  logic              M1_R_READY,

  output logic [ADDR_W-1:0] S_AR_ADDR,
  output logic              S_AR_VALID,
  input  logic              S_AR_READY,
  input  logic [DATA_W-1:0] S_R_DATA,
  input  logic [1:0]        S_R_RESP,
  input  logic              S_R_VALID,
  output logic              S_R_READY,

  output logic [1:0]        GRANT,
  output logic              BUSY
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        owner_q;
  logic [1:0]        last_q;
  logic [1:0]        arb_gnt;
  logic              r_hs;

  rr_arb2 u_arb (
    .req  ({M1_AR_VALID, M0_AR_VALID}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Slave-side R handshake as seen through the owner's steering below.
  assign r_hs = S_R_VALID && S_R_READY;

  always_comb begin
    state_d     = state_q;
    M0_AR_READY = 1'b0;
    M1_AR_READY = 1'b0;
    M0_R_DATA   = '0;
    M0_R_RESP   = OKAY;
    M0_R_VALID  = 1'b0;
    M1_R_DATA   = '0;
    M1_R_RESP   = OKAY;
    M1_R_VALID  = 1'b0;
    S_AR_ADDR   = '0;
    S_AR_VALID  = 1'b0;
    S_R_READY   = 1'b0;

    case (state_q)
      IDLE: begin
        // Suppressed during reset so no upstream handshake is silently dropped.
        M0_AR_READY = arb_gnt[M0] && !RST;
        M1_AR_READY = arb_gnt[M1] && !RST;
        if (|arb_gnt) state_d = ADDR;
      end
      ADDR: begin
        S_AR_VALID = 1'b1;
        S_AR_ADDR  = addr_q;
        if (S_AR_READY) state_d = DATA;
      end
      DATA: begin
        if (owner_q[M0]) begin
          M0_R_VALID = S_R_VALID;
          M0_R_DATA  = S_R_DATA;
          M0_R_RESP  = S_R_RESP;
          S_R_READY  = M0_R_READY;
        end else if (owner_q[M1]) begin
          M1_R_VALID = S_R_VALID;
          M1_R_DATA  = S_R_DATA;
          M1_R_RESP  = S_R_RESP;
          S_R_READY  = M1_R_READY;
        end
        if (r_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      owner_q <= 2'b00;
      last_q  <= 2'b10;  // last=M1 so M0 takes the first tie
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |arb_gnt) begin
        addr_q  <= arb_gnt[M1] ? M1_AR_ADDR : M0_AR_ADDR;
        owner_q <= arb_gnt;
      end
      if (state_q == DATA && r_hs) begin
        last_q  <= owner_q;
        owner_q <= 2'b00;
      end
    end
  end

  assign GRANT = owner_q;
  assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Directed bench for axi4_lite_read_arbiter with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: slave AR ready and master R ready driven explicitly per scenario.
module tb_axi4_lite_read_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] M0_AR_ADDR, M1_AR_ADDR, S_AR_ADDR;
  logic        M0_AR_VALID, M0_AR_READY, M1_AR_VALID, M1_AR_READY;
  logic [63:0] M0_R_DATA, M1_R_DATA, S_R_DATA;
  logic [1:0]  M0_R_RESP, M1_R_RESP, S_R_RESP;
  logic        M0_R_VALID, M0_R_READY, M1_R_VALID, M1_R_READY;
  logic        S_AR_VALID, S_AR_READY, S_R_VALID, S_R_READY;
  logic [1:0]  GRANT;
  logic        BUSY;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  axi4_lite_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .CLK(CLK), .RST(RST),
    .M0_AR_ADDR(M0_AR_ADDR), .M0_AR_VALID(M0_AR_VALID), .M0_AR_READY(M0_AR_READY),
    .M0_R_DATA(M0_R_DATA), .M0_R_RESP(M0_R_RESP), .M0_R_VALID(M0_R_VALID), .M0_R_READY(M0_R_READY),
    .M1_AR_ADDR(M1_AR_ADDR), .M1_AR_VALID(M1_AR_VALID), .M1_AR_READY(M1_AR_READY),
    .M1_R_DATA(M1_R_DATA), .M1_R_RESP(M1_R_RESP), .M1_R_VALID(M1_R_VALID), .M1_R_READY(M1_R_READY),
    .S_AR_ADDR(S_AR_ADDR), .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY),
    .S_R_DATA(S_R_DATA), .S_R_RESP(S_R_RESP), .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    M0_AR_VALID = 1'b0;
    M1_AR_VALID = 1'b0;
    S_R_VALID   = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    settle();
    chk({tag, "_grant"},   64'(GRANT), 64'd0);
    chk({tag, "_busy"},    64'(BUSY), 64'd0);
    chk({tag, "_s_arv"},   64'(S_AR_VALID), 64'd0);
    chk({tag, "_s_ara"},   S_AR_ADDR, 64'd0);
    chk({tag, "_s_rrdy"},  64'(S_R_READY), 64'd0);
    chk({tag, "_arrdy"},   64'({M1_AR_READY, M0_AR_READY}), 64'd0);
    chk({tag, "_rvalid"},  64'({M1_R_VALID, M0_R_VALID}), 64'd0);
    chk({tag, "_rdata0"},  M0_R_DATA, 64'd0);
    chk({tag, "_rdata1"},  M1_R_DATA, 64'd0);
  endtask

  // One full 3-cycle transaction with immediate slave handshakes.
  // Entered in IDLE with the caller's AR_VALIDs already driven.
  task automatic txn(input string tag, input logic [1:0] exp_gnt, input logic [63:0] exp_addr,
                     input logic [63:0] rdata, input logic [1:0] rresp);
    logic [63:0] own_data, oth_data;
    logic        own_vld, oth_vld;
    logic [1:0]  own_resp;
    settle();
    chk({tag, "_arrdy"}, 64'({M1_AR_READY, M0_AR_READY}), 64'(exp_gnt));
    chk({tag, "_idle_arv"}, 64'(S_AR_VALID), 64'd0);
    step();
    S_AR_READY = 1'b1;
    settle();
    chk({tag, "_arv"},   64'(S_AR_VALID), 64'd1);
    chk({tag, "_araddr"}, S_AR_ADDR, exp_addr);
    chk({tag, "_grant"},  64'(GRANT), 64'(exp_gnt));
    chk({tag, "_addr_arrdy"}, 64'({M1_AR_READY, M0_AR_READY}), 64'd0);
    step();
    S_R_VALID = 1'b1;
    S_R_DATA  = rdata;
    S_R_RESP  = rresp;
    settle();
    own_vld  = exp_gnt[1] ? M1_R_VALID : M0_R_VALID;
    own_data = exp_gnt[1] ? M1_R_DATA  : M0_R_DATA;
    own_resp = exp_gnt[1] ? M1_R_RESP  : M0_R_RESP;
    oth_vld  = exp_gnt[1] ? M0_R_VALID : M1_R_VALID;
    oth_data = exp_gnt[1] ? M0_R_DATA  : M1_R_DATA;
    chk({tag, "_rvalid"}, 64'(own_vld), 64'd1);
    chk({tag, "_rdata"},  own_data, rdata);
    chk({tag, "_rresp"},  64'(own_resp), 64'(rresp));
    chk({tag, "_oth_rv"}, 64'(oth_vld), 64'd0);
    chk({tag, "_oth_rd"}, oth_data, 64'd0);
    chk({tag, "_s_rrdy"}, 64'(S_R_READY), 64'd1);
    step();
    S_R_VALID = 1'b0;
    S_R_DATA  = 64'd0;
    S_R_RESP  = 2'b00;
  endtask

  initial begin
    RST = 1'b1;
    M0_AR_ADDR = 64'd0; M1_AR_ADDR = 64'd0;
    M0_AR_VALID = 1'b0; M1_AR_VALID = 1'b0;
    M0_R_READY = 1'b1;  M1_R_READY = 1'b1;
    S_AR_READY = 1'b1;
    S_R_DATA = 64'd0; S_R_RESP = 2'b00; S_R_VALID = 1'b0;

    // Reset state
    do_reset();
    check_idle_outputs("rst");

    // Single M0 read
    M0_AR_ADDR  = 64'h0000_0000_8000_0000;
    M0_AR_VALID = 1'b1;
    settle();
    chk("single_m0_arrdy", 64'(M0_AR_READY), 64'd1);
    chk("single_m1_arrdy", 64'(M1_AR_READY), 64'd0);
    chk("single_c0_arv",   64'(S_AR_VALID), 64'd0);
    chk("single_c0_busy",  64'(BUSY), 64'd0);
    step();
    M0_AR_VALID = 1'b0;
    settle();
    chk("single_c1_arv",   64'(S_AR_VALID), 64'd1);
    chk("single_c1_addr",  S_AR_ADDR, 64'h0000_0000_8000_0000);
    chk("single_c1_grant", 64'(GRANT), 64'd1);
    chk("single_c1_busy",  64'(BUSY), 64'd1);
    step();
    S_R_VALID = 1'b1;
    S_R_DATA  = 64'h1122_3344_5566_7788;
    S_R_RESP  = 2'b00;
    settle();
    chk("single_c2_rv",    64'(M0_R_VALID), 64'd1);
    chk("single_c2_rd",    M0_R_DATA, 64'h1122_3344_5566_7788);
    chk("single_c2_m1rv",  64'(M1_R_VALID), 64'd0);
    chk("single_c2_m1rd",  M1_R_DATA, 64'd0);
    chk("single_c2_arv",   64'(S_AR_VALID), 64'd0);
    step();
    S_R_VALID = 1'b0;
    check_idle_outputs("single_done");

    // Tie after reset: M0 then M1 with no extra bubble
    do_reset();
    M0_AR_ADDR = 64'h100; M1_AR_ADDR = 64'h200;
    M0_AR_VALID = 1'b1;   M1_AR_VALID = 1'b1;
    txn("tie_a", 2'b01, 64'h100, 64'hA0, 2'b00);
    txn("tie_b", 2'b10, 64'h200, 64'hB0, 2'b00);

    // Alternation with both held valid
    txn("alt0", 2'b01, 64'h100, 64'hC0, 2'b00);
    txn("alt1", 2'b10, 64'h200, 64'hC1, 2'b00);
    txn("alt2", 2'b01, 64'h100, 64'hC2, 2'b00);
    txn("alt3", 2'b10, 64'h200, 64'hC3, 2'b00);
    M0_AR_VALID = 1'b0; M1_AR_VALID = 1'b0;

    // Backpressure on AR then on M1's R
    M1_AR_ADDR  = 64'h3000;
    M1_AR_VALID = 1'b1;
    S_AR_READY  = 1'b0;
    settle();
    chk("bp_m1_arrdy", 64'(M1_AR_READY), 64'd1);
    step();
    M1_AR_VALID = 1'b0;
    M1_AR_ADDR  = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_ar_vld",  64'(S_AR_VALID), 64'd1);
      chk("bp_ar_addr", S_AR_ADDR, 64'h3000);
      chk("bp_ar_grant", 64'(GRANT), 64'd2);
      step();
    end
    S_AR_READY = 1'b1;
    settle();
    chk("bp_ar_vld_hs",  64'(S_AR_VALID), 64'd1);
    chk("bp_ar_addr_hs", S_AR_ADDR, 64'h3000);
    step();
    M1_R_READY = 1'b0;
    S_R_VALID  = 1'b1;
    S_R_DATA   = 64'h55AA;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_s_rrdy",  64'(S_R_READY), 64'd0);
      chk("bp_m1_rv",   64'(M1_R_VALID), 64'd1);
      chk("bp_r_busy",  64'(BUSY), 64'd1);
      chk("bp_r_arv",   64'(S_AR_VALID), 64'd0);
      step();
    end
    M1_R_READY = 1'b1;
    settle();
    chk("bp_s_rrdy_hs", 64'(S_R_READY), 64'd1);
    chk("bp_m1_rd",     M1_R_DATA, 64'h55AA);
    step();
    S_R_VALID = 1'b0;
    check_idle_outputs("bp_done");

    // Error pass-through to M1
    M1_AR_ADDR  = 64'h4000;
    M1_AR_VALID = 1'b1;
    txn("err", 2'b10, 64'h4000, 64'hEE, 2'b10);
    M1_AR_VALID = 1'b0;
    check_idle_outputs("err_done");

    // Reset in DATA abandons the transaction; next tie goes to M0
    M1_AR_ADDR  = 64'h5000;
    M1_AR_VALID = 1'b1;
    step();
    M1_AR_VALID = 1'b0;
    step();
    settle();
    chk("mrst_in_data", 64'(BUSY), 64'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_idle_outputs("mrst");
    M0_AR_ADDR = 64'h600; M1_AR_ADDR = 64'h700;
    M0_AR_VALID = 1'b1;   M1_AR_VALID = 1'b1;
    txn("mrst_tie", 2'b01, 64'h600, 64'h66, 2'b00);
    M0_AR_VALID = 1'b0; M1_AR_VALID = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
